// File: rtl/tartaruga_pkg.sv
// Shared types for the tartaruga core's memory stage: bus type, memory op
// encoding and LSU state.
package tartaruga_pkg;

  typedef logic [31:0] bus32_t;

  // {store, funct3}: funct3[2] marks unsigned loads and funct3[1:0] is the size.
  typedef enum logic [3:0] {
    LB  = 4'b0_000,
    LH  = 4'b0_001,
    LW  = 4'b0_010,
    LBU = 4'b0_100,
    LHU = 4'b0_101,
    SB  = 4'b1_000,
    SH  = 4'b1_001,
    SW  = 4'b1_010
  } mem_op_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WRITE  = 2'd2
  } lsu_state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam bus32_t TOHOST_ADDR = 32'h4000_0000;

  function automatic logic op_is_store(input mem_op_t op);
    logic [3:0] enc;
    enc = op;
    return enc[3];
  endfunction

  function automatic logic op_is_unsigned(input mem_op_t op);
    logic [3:0] enc;
    enc = op;
    return enc[2];
  endfunction

  function automatic logic [1:0] op_size(input mem_op_t op);
    logic [3:0] enc;
    enc = op;
    return enc[1:0];
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for the LSU: load extraction with sign/zero
// extension, sub-word store merge and alignment check.
module lsu_align
  import tartaruga_pkg::*;
(
  input  mem_op_t    op,
  input  logic [1:0] byte_off,
  input  bus32_t     rd_word,
  input  bus32_t     store_data,
  output bus32_t     load_data,
  output bus32_t     merged_word,
  output logic       misaligned
);

  logic        [7:0]  lane_b;
  logic        [15:0] lane_h;
  logic signed [7:0]  lane_b_s;
  logic signed [15:0] lane_h_s;
  logic signed [31:0] ext_b;
  logic signed [31:0] ext_h;

  always_comb begin
    lane_b = rd_word[7:0];
    unique case (byte_off)
      2'd0: lane_b = rd_word[7:0];
      2'd1: lane_b = rd_word[15:8];
      2'd2: lane_b = rd_word[23:16];
      2'd3: lane_b = rd_word[31:24];
      default: lane_b = rd_word[7:0];
    endcase
    lane_h   = byte_off[1] ? rd_word[31:16] : rd_word[15:0];
    lane_b_s = lane_b;
    lane_h_s = lane_h;
    ext_b    = 32'(lane_b_s);
    ext_h    = 32'(lane_h_s);
  end

  always_comb begin
    misaligned = 1'b0;
    unique case (op_size(op))
      SZ_HALF: misaligned = byte_off[0];
      SZ_WORD: misaligned = |byte_off;
      default: misaligned = 1'b0;
    endcase
  end

  always_comb begin
    load_data = rd_word;
    unique case (op_size(op))
      SZ_BYTE: load_data = op_is_unsigned(op) ? {24'd0, lane_b} : ext_b;
      SZ_HALF: load_data = op_is_unsigned(op) ? {16'd0, lane_h} : ext_h;
      default: load_data = rd_word;
    endcase
  end

  // Only the addressed lane is replaced; the rest of the read word survives.
  always_comb begin
    merged_word = rd_word;
    if (op == SB) begin
      unique case (byte_off)
        2'd0: merged_word[7:0]   = store_data[7:0];
        2'd1: merged_word[15:8]  = store_data[7:0];
        2'd2: merged_word[23:16] = store_data[7:0];
        2'd3: merged_word[31:24] = store_data[7:0];
        default: merged_word = rd_word;
      endcase
    end else if (op == SH) begin
      if (byte_off[1]) merged_word[31:16] = store_data[15:0];
      else             merged_word[15:0]  = store_data[15:0];
    end
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// MEM-stage load/store unit in front of the word-addressed data memory.
// Sub-word stores run as read-modify-write over two dmem cycles.
module lsu_mem_stage
  import tartaruga_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  mem_op_t           op_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] store_data_i,
  input  logic [ADDR_W-1:0] pc_i,
  output logic              resp_valid_o,
  output logic [DATA_W-1:0] load_data_o,
  output logic              misaligned_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [DATA_W-1:0] dmem_data_wr_o,
  output logic              dmem_we_o,
  output logic [ADDR_W-1:0] dmem_pc_o,
  input  logic [DATA_W-1:0] dmem_data_rd_i
);

  lsu_state_t        state_q;
  mem_op_t           op_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic [DATA_W-1:0] sdata_p0;
  logic [ADDR_W-1:0] pc_p0;
  logic [DATA_W-1:0] merged_p1;

  bus32_t            align_load;
  bus32_t            align_merged;
  logic              align_mis;

  lsu_align u_align (
    .op          (op_p0),
    .byte_off    (addr_p0[1:0]),
    .rd_word     (dmem_data_rd_i),
    .store_data  (sdata_p0),
    .load_data   (align_load),
    .merged_word (align_merged),
    .misaligned  (align_mis)
  );

  assign req_ready_o    = (state_q == IDLE);
  assign dmem_addr_o    = {addr_p0[ADDR_W-1:2], 2'b00};
  assign dmem_pc_o      = pc_p0;
  assign dmem_data_wr_o = (state_q == WRITE) ? merged_p1 : sdata_p0;

  // Reset gates the strobe combinationally so a WRITE cut short by reset never lands.
  assign dmem_we_o = !rst_i &&
                     ((state_q == WRITE) ||
                      (state_q == ACCESS && op_p0 == SW && !align_mis));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      resp_valid_o <= 1'b0;
      misaligned_o <= 1'b0;
      load_data_o  <= '0;
      op_p0        <= LB;
      addr_p0      <= '0;
      sdata_p0     <= '0;
      pc_p0        <= '0;
      merged_p1    <= '0;
    end else begin
      resp_valid_o <= 1'b0;
      unique case (state_q)
        // p0: request latch
        IDLE: begin
          if (req_valid_i) begin
            op_p0    <= op_i;
            addr_p0  <= addr_i;
            sdata_p0 <= store_data_i;
            pc_p0    <= pc_i;
            state_q  <= ACCESS;
          end
        end
        // p1: dmem access, load extract or merge capture
        ACCESS: begin
          if (align_mis) begin
            resp_valid_o <= 1'b1;
            misaligned_o <= 1'b1;
            load_data_o  <= '0;
            state_q      <= IDLE;
          end else if (!op_is_store(op_p0)) begin
            resp_valid_o <= 1'b1;
            misaligned_o <= 1'b0;
            load_data_o  <= align_load;
            state_q      <= IDLE;
          end else if (op_p0 == SW) begin
            resp_valid_o <= 1'b1;
            misaligned_o <= 1'b0;
            load_data_o  <= '0;
            state_q      <= IDLE;
          end else begin
            merged_p1 <= align_merged;
            state_q   <= WRITE;
          end
        end
        // p2: merged word write-back
        WRITE: begin
          resp_valid_o <= 1'b1;
          misaligned_o <= 1'b0;
          load_data_o  <= '0;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Scoreboard bench for lsu_mem_stage: a word-level reference model predicts
// responses and dmem writes, monitors compare them as the DUT emits them.
module tb_lsu_mem_stage;
  import tartaruga_pkg::*;

  localparam time P = 10;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  mem_op_t     op_i = LB;
  logic [31:0] addr_i = '0;
  logic [31:0] store_data_i = '0;
  logic [31:0] pc_i = '0;
  logic        resp_valid_o;
  logic [31:0] load_data_o;
  logic        misaligned_o;
  logic [31:0] dmem_addr_o;
  logic [31:0] dmem_data_wr_o;
  logic        dmem_we_o;
  logic [31:0] dmem_pc_o;
  logic [31:0] dmem_data_rd_i = '0;

  lsu_mem_stage #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .op_i(op_i), .addr_i(addr_i), .store_data_i(store_data_i), .pc_i(pc_i),
    .resp_valid_o(resp_valid_o), .load_data_o(load_data_o), .misaligned_o(misaligned_o),
    .dmem_addr_o(dmem_addr_o), .dmem_data_wr_o(dmem_data_wr_o), .dmem_we_o(dmem_we_o),
    .dmem_pc_o(dmem_pc_o), .dmem_data_rd_i(dmem_data_rd_i)
  );

  always #(P/2) clk_i = ~clk_i;

  typedef struct { logic [31:0] data; logic mis; time t; } resp_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; logic [31:0] pc; time t; } wr_t;

  resp_t       resp_q[$];
  wr_t         wr_q[$];
  logic [31:0] model_mem[logic [31:0]];
  logic [31:0] phys_mem[logic [31:0]];
  int          vectors = 0;
  int          miscompares = 0;
  int          pulses = 0;
  logic [31:0] pc_ctr = 32'h0000_1000;
  time         last_acc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mread(input logic [31:0] a);
    return model_mem.exists(a) ? model_mem[a] : 32'h0;
  endfunction

  function automatic logic [31:0] pread(input logic [31:0] a);
    return phys_mem.exists(a) ? phys_mem[a] : 32'h0;
  endfunction

  task automatic poke(input logic [31:0] a, input logic [31:0] d);
    model_mem[a & ~32'h3] = d;
    phys_mem[a & ~32'h3]  = d;
  endtask

  // Reference model: byte-addressed semantics computed with shifts and masks.
  task automatic predict(input mem_op_t op, input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] pc, input time t);
    resp_t       r;
    wr_t         w;
    logic [31:0] wa, word, mask, nw;
    int          nbytes, sh, v;
    bit          is_st, uns;
    wa     = a & ~32'h3;
    word   = mread(wa);
    sh     = 8 * int'(a[1:0]);
    is_st  = (op == SB || op == SH || op == SW);
    uns    = (op == LBU || op == LHU);
    nbytes = (op == LB || op == LBU || op == SB) ? 1 : (op == LH || op == LHU || op == SH) ? 2 : 4;
    r.t    = t + P + P/2;
    r.mis  = (int'(a[1:0]) % nbytes) != 0;
    r.data = 32'h0;
    if (!r.mis && !is_st) begin
      if (nbytes == 4) r.data = word;
      else begin
        v = int'((word >> sh) & ((32'h1 << (8 * nbytes)) - 1));
        if (!uns && v >= (1 << (8 * nbytes - 1))) v = v - (1 << (8 * nbytes));
        r.data = 32'(v);
      end
    end else if (!r.mis) begin
      mask = (nbytes == 4) ? 32'hFFFF_FFFF : (((32'h1 << (8 * nbytes)) - 1) << sh);
      nw   = (word & ~mask) | ((d << sh) & mask);
      w.addr = wa; w.data = nw; w.pc = pc;
      w.t  = (nbytes == 4) ? t + P : t + 2 * P;
      if (nbytes != 4) r.t = t + 2 * P + P/2;
      wr_q.push_back(w);
      model_mem[wa] = nw;
    end
    resp_q.push_back(r);
  endtask

  task automatic issue(input mem_op_t op, input logic [31:0] a, input logic [31:0] d);
    bit ok = 0;
    @(negedge clk_i);
    req_valid_i = 1'b1; op_i = op; addr_i = a; store_data_i = d; pc_i = pc_ctr;
    pc_ctr += 4;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(posedge clk_i);
      if (req_ready_o && !rst_i) ok = 1;
    end
    if (!ok) begin
      vectors++; miscompares++;
      $display("FAIL accept_timeout: got no accept expected accept within 20 cycles");
      req_valid_i = 1'b0;
      return;
    end
    last_acc = $time;
    predict(op, a, d, pc_i, $time);
  endtask

  task automatic idle(input int n);
    @(negedge clk_i);
    req_valid_i = 1'b0;
    repeat (n) @(negedge clk_i);
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && (resp_q.size() != 0 || wr_q.size() != 0); i++) @(negedge clk_i);
    chk("resp_queue_empty", 32'(resp_q.size()), 32'd0);
    chk("write_queue_empty", 32'(wr_q.size()), 32'd0);
  endtask

  // Response monitor.
  always @(negedge clk_i) begin
    if (resp_valid_o) begin
      pulses++;
      if (resp_q.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL unexpected_resp: got resp_valid_o=1 expected 0 at %0t", $time);
      end else begin
        resp_t e;
        e = resp_q.pop_front();
        chk("resp_time", 32'($time), 32'(e.t));
        chk("misaligned", {31'd0, misaligned_o}, {31'd0, e.mis});
        chk("load_data", load_data_o, e.data);
      end
    end
  end

  // Data memory: write port observed on the active edge, read presented at negedge.
  always @(posedge clk_i) begin
    if (dmem_we_o) begin
      if (wr_q.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL unexpected_write: got we addr %h data %h expected no write", dmem_addr_o, dmem_data_wr_o);
      end else begin
        wr_t e;
        e = wr_q.pop_front();
        chk("wr_addr", dmem_addr_o, e.addr);
        chk("wr_data", dmem_data_wr_o, e.data);
        chk("wr_pc", dmem_pc_o, e.pc);
        chk("wr_time", 32'($time), 32'(e.t));
      end
      phys_mem[dmem_addr_o] = dmem_data_wr_o;
    end
  end

  always @(negedge clk_i) dmem_data_rd_i = pread(dmem_addr_o);

  initial begin
    #(50000 * P);
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    mem_op_t     ops[8] = '{LB, LH, LW, LBU, LHU, SB, SH, SW};
    time         acc[3];
    int          p0;
    logic [31:0] saved;

    // Reset with a simultaneous request: reset must win.
    req_valid_i = 1'b1; op_i = SW; addr_i = 32'h0000_1234; store_data_i = 32'hFFFF_FFFF; pc_i = 32'h55;
    repeat (3) @(negedge clk_i);
    chk("rst_resp_valid", {31'd0, resp_valid_o}, 32'd0);
    chk("rst_misaligned", {31'd0, misaligned_o}, 32'd0);
    chk("rst_load_data", load_data_o, 32'd0);
    chk("rst_we", {31'd0, dmem_we_o}, 32'd0);
    chk("rst_addr", dmem_addr_o, 32'd0);
    rst_i = 1'b0; req_valid_i = 1'b0;
    @(negedge clk_i);
    chk("post_rst_ready", {31'd0, req_ready_o}, 32'd1);
    chk("post_rst_addr", dmem_addr_o, 32'd0);
    chk("post_rst_pc", dmem_pc_o, 32'd0);

    issue(SW, 32'h100, 32'hDEAD_BEEF);
    issue(LW, 32'h100, 32'h0);
    idle(2);

    poke(32'h200, 32'h80FF_7F01);
    issue(LB, 32'h203, 32'h0);
    issue(LBU, 32'h201, 32'h0);
    issue(LH, 32'h202, 32'h0);
    issue(LHU, 32'h200, 32'h0);
    idle(2);

    poke(32'h300, 32'h1122_3344);
    issue(SB, 32'h301, 32'h0000_00AB);
    issue(SH, 32'h302, 32'h0000_CDEF);
    issue(LW, 32'h300, 32'h0);
    idle(2);

    issue(LW, 32'h102, 32'h0);
    issue(SH, 32'h101, 32'h1234);
    issue(LH, 32'h203, 32'h0);
    idle(2);
    drain();
    chk("mis_mem_100", pread(32'h100), 32'hDEAD_BEEF);
    chk("mis_mem_200", pread(32'h200), 32'h80FF_7F01);

    // Back-to-back with req_valid_i held high.
    p0 = pulses;
    issue(SW, 32'h120, 32'hCAFE_F00D); acc[0] = last_acc;
    issue(LW, 32'h120, 32'h0);         acc[1] = last_acc;
    issue(SB, 32'h121, 32'h0000_0099); acc[2] = last_acc;
    idle(1);
    drain();
    chk("b2b_gap_1", 32'(acc[1] - acc[0]), 32'(2 * P));
    chk("b2b_gap_2", 32'(acc[2] - acc[1]), 32'(2 * P));
    chk("b2b_pulses", 32'(pulses - p0), 32'd3);

    poke(TOHOST_ADDR, 32'h0);
    issue(SB, TOHOST_ADDR | 32'h1, 32'h0000_005A);
    idle(1);
    drain();

    // Reset while the SB merge word sits in WRITE.
    poke(32'h300, 32'h1122_3344);
    saved = 32'h1122_3344;
    issue(SB, 32'h302, 32'h0000_0077);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1; req_valid_i = 1'b0;
    @(negedge clk_i);
    chk("rst_write_resp", {31'd0, resp_valid_o}, 32'd0);
    chk("rst_write_we", {31'd0, dmem_we_o}, 32'd0);
    resp_q.delete();
    wr_q.delete();
    model_mem[32'h300] = saved;
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("rst_write_ready", {31'd0, req_ready_o}, 32'd1);
    chk("rst_write_mem", pread(32'h300), saved);
    issue(LW, 32'h300, 32'h0);
    idle(1);
    drain();

    // Randomised traffic over a small window.
    for (int i = 0; i < 16; i++) poke(32'h100 + 32'(4 * i), $urandom);
    for (int i = 0; i < 300; i++) begin
      issue(ops[$urandom_range(0, 7)], 32'h100 + 32'($urandom_range(0, 63)), $urandom);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(0, 3));
    end
    idle(1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
- Load/store unit of the MEM pipeline stage, directly upstream of the word-addressed data memory.
- Accepts one memory request from EX: op, address, store data and PC.
- Drives the word-only dmem interface: address, write data, write enable, PC.
- Performs byte/half extraction with sign/zero extension for loads, and read-modify-write for sub-word stores.
- Flags misaligned accesses and returns one response per request.

Parameters:
- ADDR_W, 32, address width (bus32_t)
- DATA_W, 32, data width (bus32_t)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; one clock; reset is synchronous and active-high
- req_valid_i  in  1  request present from EX
- req_ready_o  out  1  unit can accept a request this cycle
- op_i  in  mem_op_t  LB, LH, LW, LBU, LHU, SB, SH, SW
- addr_i  in  32  byte address
- store_data_i  in  32  store source (low bits used for SB/SH)
- pc_i  in  32  PC of the instruction
- resp_valid_o  out  1  one-cycle pulse, response ready
- load_data_o  out  32  extended load result (0 for stores)
- misaligned_o  out  1  qualifies resp_valid_o; access was not performed
- dmem_addr_o  out  32  word-aligned address ({addr[31:2],2'b00})
- dmem_data_wr_o  out  32  word to write
- dmem_we_o  out  1  write enable
- dmem_pc_o  out  32  latched PC, forwarded for the tohost message
- dmem_data_rd_i  in  32  combinational read word from dmem

Behaviour:
- FSM states: IDLE, ACCESS, WRITE.
- Reset values: state=IDLE, resp_valid_o=0, misaligned_o=0, load_data_o=0, all latched request registers=0.
- dmem_we_o is 0 while rst_i=1 and in IDLE/ACCESS-with-load.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i, latch op/addr/store_data/pc and go to ACCESS.
  - Request accept in cycle N means dmem is driven in N+1.
- ACCESS: dmem outputs are driven from the latched registers.
  - Misaligned request:
    - Condition: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0.
    - dmem_we_o=0.
    - Set resp_valid_o=1 and misaligned_o=1 for the next cycle; go to IDLE.
  - Load:
    - Extract from dmem_data_rd_i.
    - LB/LBU: byte lane addr[1:0], sign/zero-extended.
    - LH/LHU: half addr[1], sign/zero-extended.
    - LW: full word.
    - Register the result into load_data_o, pulse resp_valid_o next cycle, go to IDLE.
    - Latency: accept N, response N+2.
  - SW:
    - dmem_we_o=1, dmem_data_wr_o=store_data.
    - Pulse response next cycle, go to IDLE.
    - Latency N+2.
  - SB/SH:
    - dmem_we_o=0; read dmem_data_rd_i.
    - Register the merged word: SB replaces byte lane addr[1:0] with store_data[7:0]; SH replaces half addr[1] with store_data[15:0].
    - Go to WRITE.
- WRITE:
  - dmem_we_o=1, dmem_data_wr_o=merged word.
  - Pulse response next cycle, go to IDLE.
  - Latency N+3.
- Response rules:
  - resp_valid_o is high exactly one cycle per accepted request.
  - load_data_o holds its value until the next response.
  - misaligned_o=0 on aligned responses.
- Throughput:
  - req_ready_o=0 in ACCESS and WRITE.
  - The response cycle is IDLE, so a new request may be accepted in the same cycle resp_valid_o=1 (back-to-back).
- Requests while not ready are ignored. EX holds the request until req_ready_o.
- Reset mid-operation:
  - At the next edge, state→IDLE and all registers clear.
  - No write is issued in WRITE if rst_i=1 that cycle.
  - A pending response is dropped.
- Simultaneous reset and request: reset wins; the request is not latched.
- tohost at 0x40000000 must be issued as SW. A sub-word store there performs RMW, and its write still triggers termination.

Decomposition:
- tartaruga_pkg:
  - mem_op_t enum with LB, LH, LW, LBU, LHU, SB, SH, SW (encoded funct3 + store bit).
  - lsu_state_t enum.
  - TOHOST_ADDR = 32'h40000000.
  - bus32_t, already present.
- Sub-module lsu_align: purely combinational.
  - Load extraction/extension.
  - Store merge.
  - Misalignment check.
  - Instantiated once inside lsu_mem_stage.

Test Plan:
- SW addr 0x100, data 0xDEADBEEF:
  - dmem_we_o=1 in N+1 with dmem_addr_o=0x100, resp N+2.
  - Then LW 0x100 → load_data_o=0xDEADBEEF at N+2.
- Word 0x80FF7F01 at 0x200:
  - LB 0x203 → 0xFFFFFF80.
  - LBU 0x201 → 0x0000007F.
  - LH 0x202 → 0xFFFF80FF.
  - LHU 0x200 → 0x00007F01.
- Word 0x11223344 at 0x300:
  - SB 0x301 data 0xAB → one read cycle, then a write of 0x1122AB44, resp N+3.
  - SH 0x302 data 0xCDEF → 0xCDEFAB44.
- LW 0x102, SH 0x101, LH 0x203:
  - Each gives misaligned_o=1 with resp at N+2.
  - dmem_we_o never asserts; memory is unchanged.
- Back-to-back, with req_valid_i held high across SW, LW, SB:
  - Each accepted in the cycle of the previous resp_valid_o pulse.
  - Exactly three pulses occur.
- rst_i asserted during WRITE of an SB:
  - No write occurs; state is IDLE and resp_valid_o=0 next cycle.
  - req_ready_o=1 after reset deasserts.
